// File: rtl/serial_comp_collector.sv
// Serial-to-parallel collector for the 2's complementer output stream.
// Rebuilds LSB-first words and holds them in a one-entry valid/ready buffer.
module serial_comp_collector #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_bit,
    input  logic             sin_valid,
    input  logic             sin_first,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CW-1:0]    bit_cnt,
    output logic             frame_err,
    output logic             overflow,
    input  logic             clr_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-2:0] TOP  = (WIDTH-1)'(1) << (WIDTH - 2);

    state_t             state_q, state_d;
    logic [WIDTH-2:0]   sreg_q, sreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-2:0]   msb;
    logic [WIDTH-1:0]   new_word;
    logic               complete;
    logic               ferr_set;
    logic               ovf_set;

    // Holds only the WIDTH-1 bits seen so far; the last bit joins at completion.
    assign msb      = sin_bit ? TOP : '0;
    assign new_word = {sin_bit, sreg_q};

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sin_valid) begin
                    if (sin_first) begin
                        sreg_d  = msb;
                        cnt_d   = CW'(1);
                        state_d = SHIFT;
                    end else begin
                        ferr_set = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    if (sin_first) begin
                        sreg_d   = msb;
                        cnt_d    = CW'(1);
                        ferr_set = 1'b1;
                    end else if (cnt_q == LAST) begin
                        complete = 1'b1;
                        sreg_d   = '0;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        sreg_d = (sreg_q >> 1) | msb;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
            end
        endcase
    end

    // A consume on the completing edge frees the slot for the new word.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovf_set = 1'b0;
        if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || word_ready) begin
                word_d  = new_word;
                valid_d = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end
        ferr_d = (clr_err ? 1'b0 : ferr_q) | ferr_set;
        ovf_d  = (clr_err ? 1'b0 : ovf_q) | ovf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign bit_cnt    = cnt_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_comp_collector.sv
// Bench for serial_comp_collector: scoreboarded word transfers plus
// per-scenario checks of counters, flags and async reset.
module tb_serial_comp_collector;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             sin_bit;
    logic             sin_valid;
    logic             sin_first;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;
    logic [CW-1:0]    bit_cnt;
    logic             frame_err;
    logic             overflow;
    logic             clr_err;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb[$];

    serial_comp_collector #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin_bit    (sin_bit),
        .sin_valid  (sin_valid),
        .sin_first  (sin_first),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_cnt    (bit_cnt),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+2, so negedge sees the values the next edge uses.
    always @(negedge clk) begin
        if (rst === 1'b0 && word_valid === 1'b1 && word_ready === 1'b1) begin
            logic [WIDTH-1:0] exp;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected got %b expected none", word_out);
            end else begin
                exp = sb.pop_front();
                if (word_out !== exp) begin
                    errors++;
                    $display("FAIL xfer_word got %b expected %b", word_out, exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b, input logic f);
        sin_valid = 1'b1;
        sin_bit   = b;
        sin_first = f;
        step();
        sin_valid = 1'b0;
        sin_first = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit push);
        if (push) sb.push_back(w);
        for (int i = 0; i < WIDTH; i++) drive_bit(w[i], i == 0);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sin_bit = 1'b0; sin_valid = 1'b0; sin_first = 1'b0;
        word_ready = 1'b0; clr_err = 1'b0;
        #12;
        if (word_out !== '0) begin errors++; $display("FAIL rst_word got %b expected 0", word_out); end
        checks++;
        if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b expected 0", word_valid); end
        checks++;
        if (bit_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d expected 0", bit_cnt); end
        checks++;
        if (frame_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got %b%b expected 00", frame_err, overflow);
        end
        checks++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        word_ready = 1'b1;
        send_word(4'b1111, 1'b1);
        checks++;
        if (word_valid !== 1'b1 || word_out !== 4'b1111) begin
            errors++;
            $display("FAIL basic_present got %b/%b expected 1/1111", word_valid, word_out);
        end
        step();
        checks++;
        if (word_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear got %b expected 0", word_valid);
        end
    endtask

    task automatic test_bit_order();
        logic [WIDTH-1:0] w;
        w = 4'b0101;
        word_ready = 1'b1;
        sb.push_back(w);
        for (int i = 0; i < WIDTH; i++) begin
            drive_bit(w[i], i == 0);
            if (i < WIDTH - 1) chk("order_cnt", int'(bit_cnt), i + 1);
            else chk("order_cnt_end", int'(bit_cnt), 0);
        end
        chk("order_word", int'(word_out), 5);
        step();
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        send_word(4'b1111, 1'b1);
        chk("bp_ovf_first", int'(overflow), 0);
        send_word(4'b0011, 1'b0);
        chk("bp_ovf_set", int'(overflow), 1);
        chk("bp_word_kept", int'(word_out), 15);
        chk("bp_valid_kept", int'(word_valid), 1);
        word_ready = 1'b1;
        step();
        step();
        chk("bp_drained", int'(word_valid), 0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("bp_ovf_clr", int'(overflow), 0);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] b;
        b = 4'b1001;
        word_ready = 1'b0;
        send_word(4'b0110, 1'b1);
        sb.push_back(b);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) word_ready = 1'b1;
            drive_bit(b[i], i == 0);
        end
        word_ready = 1'b0;
        chk("b2b_valid", int'(word_valid), 1);
        chk("b2b_word", int'(word_out), 9);
        chk("b2b_ovf", int'(overflow), 0);
        word_ready = 1'b1;
        step();
        step();
    endtask

    task automatic test_framing();
        logic [WIDTH-1:0] w;
        w = 4'b1101;
        word_ready = 1'b1;
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        chk("frm_no_err", int'(frame_err), 0);
        sb.push_back(w);
        drive_bit(w[0], 1'b1);
        chk("frm_restart_err", int'(frame_err), 1);
        chk("frm_restart_cnt", int'(bit_cnt), 1);
        for (int i = 1; i < WIDTH; i++) drive_bit(w[i], 1'b0);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("frm_clr", int'(frame_err), 0);
        drive_bit(1'b1, 1'b0);
        chk("frm_stray", int'(frame_err), 1);
        chk("frm_stray_cnt", int'(bit_cnt), 0);
        clr_err = 1'b1;
        drive_bit(1'b1, 1'b0);
        clr_err = 1'b0;
        chk("frm_set_wins", int'(frame_err), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        // sin_first on what would be the last bit restarts instead of completing
        w = 4'b0110;
        for (int i = 0; i < WIDTH - 1; i++) drive_bit(1'b1, i == 0);
        sb.push_back(w);
        drive_bit(w[0], 1'b1);
        chk("frm_last_err", int'(frame_err), 1);
        chk("frm_last_cnt", int'(bit_cnt), 1);
        chk("frm_last_noval", int'(word_valid), 0);
        for (int i = 1; i < WIDTH; i++) drive_bit(w[i], 1'b0);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic test_async_reset();
        word_ready = 1'b0;
        send_word(4'b1010, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b0, 1'b0);
        chk("ar_pre_cnt", int'(bit_cnt), 2);
        chk("ar_pre_valid", int'(word_valid), 1);
        chk("ar_pre_ferr", int'(frame_err), 1);
        #1 rst = 1'b1;
        #1;
        chk("ar_cnt", int'(bit_cnt), 0);
        chk("ar_valid", int'(word_valid), 0);
        chk("ar_word", int'(word_out), 0);
        chk("ar_flags", int'({frame_err, overflow}), 0);
        #2 rst = 1'b0;
        step();
        word_ready = 1'b1;
        send_word(4'b0011, 1'b1);
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bit_order();
        test_backpressure();
        test_back_to_back();
        test_framing();
        test_async_reset();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
